logic_op_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit with valid/ready handshakes on input and output. It replaces the fixed 16-bit, 4-op combinational selector with a WIDTH-generic, 8-op datapath. Every op select value is fully decoded, so no latches are inferred. Results are registered, and an accumulate mode feeds the previous result back as operand A. It sits between an operand source and a result consumer in the in-class datapath exercises.

---
 rtl/logic_op_unit.sv | 147 ++++++++++++++
 tb/tb_logic_op_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_unit.sv
// logic_op_unit: two-stage pipelined bitwise logic unit.
//   S1 registers an operand beat {op, use_acc, a, b}; S2 computes the result
//   and holds it in y until the consumer takes it. With use_acc set, operand A
//   is the current y, which is the result of the immediately preceding op.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
//   high. Valid never depends on ready. in_ready depends on out_ready only,
//   never on in_valid.
// Optional: define LOGIC_OP_UNIT_FLAGS_EN to add the registered zero/parity flags.
module logic_op_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef LOGIC_OP_UNIT_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q;
  logic             s1_use_acc_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Handshake and transfer strobes
  logic             s2_can_load;
  logic             s2_load;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] op_a;

  // S2 is free when it is empty or its result leaves on this edge.
  always_comb begin
    s2_can_load = !out_valid_q || out_ready;
    s2_load     = s1_valid_q && s2_can_load;
    in_ready    = !s1_valid_q || s2_can_load;
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid_q && out_ready;
  end

  // Operand A select and the fully decoded op table.
  always_comb begin
    op_a = s1_use_acc_q ? y_q : s1_a_q;
    y_d  = op_a;
    case (op_e'(s1_op_q))
      OP_AND:  y_d = op_a & s1_b_q;
      OP_OR:   y_d = op_a | s1_b_q;
      OP_XOR:  y_d = op_a ^ s1_b_q;
      OP_NAND: y_d = ~(op_a & s1_b_q);
      OP_NOR:  y_d = ~(op_a | s1_b_q);
      OP_XNOR: y_d = ~(op_a ^ s1_b_q);
      OP_PASS: y_d = op_a;
      OP_NOT:  y_d = ~op_a;
    endcase
  end

  // Valid bits: a load refills, a drain empties, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    out_valid_d = out_valid_q;
    if (s2_load)       out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;
  end

  // Stage 1 operand register, loaded on an input handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 3'd0;
      s1_use_acc_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_op_q      <= op;
        s1_use_acc_q <= use_acc;
        s1_a_q       <= a;
        s1_b_q       <= b;
      end
    end
  end

  // Stage 2 result register; y only changes on a load and holds after consumption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) y_q <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

`ifdef LOGIC_OP_UNIT_FLAGS_EN
  logic zero_q;
  logic parity_q;

  // Flags are computed from the value being loaded so they track y exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (s2_load) begin
      zero_q   <= (y_d == '0);
      parity_q <= ^y_d;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_unit.sv
// tb_logic_op_unit: directed and randomized checks of logic_op_unit (WIDTH=16).
// Inputs are driven 1 ns after the rising edge; outputs and handshakes are
// sampled on the falling edge, where the edge-to-come transfers are already known.
module tb_logic_op_unit;
  localparam int W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic         use_acc = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
`ifdef LOGIC_OP_UNIT_FLAGS_EN
  logic         zero;
  logic         parity;
`endif

  always #5 clk = ~clk;

  logic_op_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .use_acc   (use_acc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef LOGIC_OP_UNIT_FLAGS_EN
    ,
    .zero      (zero),
    .parity    (parity)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m;
  int           n_cmp;
  int           n_err;
  logic         rand_done;
  logic [W-1:0] sweep_exp [8];

  // Reference: the op table applied to whole words.
  function automatic logic [W-1:0] ref_op(input int code, input logic [W-1:0] x, input logic [W-1:0] z);
    case (code)
      0: return x & z;
      1: return x | z;
      2: return x ^ z;
      3: return ~(x & z);
      4: return ~(x | z);
      5: return ~(x ^ z);
      6: return x;
      default: return ~x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until the handshake edge has passed.
  task automatic send(input logic [2:0] op_v, input logic acc_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    logic ok;
    ok       = 1'b0;
    op       = op_v;
    use_acc  = acc_v;
    a        = a_v;
    b        = b_v;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    check("send_accepted", {31'd0, ok}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted beat is modelled in order; every consumed result is compared.
  task automatic monitor();
    logic [W-1:0] opa;
    logic [W-1:0] r;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        acc_m = '0;
      end else begin
        if (in_valid && in_ready) begin
          opa = use_acc ? acc_m : a;
          r   = ref_op(int'(op), opa, b);
          acc_m = r;
          exp_q.push_back(r);
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_y", {16'd0, y}, {16'd0, e});
`ifdef LOGIC_OP_UNIT_FLAGS_EN
            check("sb_zero", {31'd0, zero}, {31'd0, e == '0});
            check("sb_parity", {31'd0, parity}, {31'd0, ^e});
`endif
          end
        end
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    acc_m = '0;
    rand_done = 1'b0;
    sweep_exp = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0, 16'h0F0F};
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
`ifdef LOGIC_OP_UNIT_FLAGS_EN
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_parity", {31'd0, parity}, 32'd0);
`endif
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Op sweep, back to back: result j appears at the second sample after its drive
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        op       = 3'(j);
        use_acc  = 1'b0;
        a        = 16'hF0F0;
        b        = 16'hFF00;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 8) check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
      if (j >= 2) begin
        check("sweep_out_valid", {31'd0, out_valid}, 32'd1);
        check("sweep_y", {16'd0, y}, {16'd0, sweep_exp[j-2]});
      end
      step();
    end

    // Accumulate chain
    send(3'd2, 1'b0, 16'h1234, 16'h00FF);
    repeat (2) @(negedge clk);
    check("acc_y1", {16'd0, y}, 32'h12CB);
    step();
    send(3'd2, 1'b1, 16'($urandom), 16'h00FF);
    repeat (2) @(negedge clk);
    check("acc_y2", {16'd0, y}, 32'h1234);
    step();
    send(3'd0, 1'b1, 16'($urandom), 16'h0F0F);
    repeat (2) @(negedge clk);
    check("acc_y3", {16'd0, y}, 32'h0204);
    step();

    // Backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd2; use_acc = 1'b0; a = 16'h1111; b = 16'h0101;
    @(negedge clk);
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    op = 3'd1; a = 16'h00F0; b = 16'h0F00;
    @(negedge clk);
    check("bp_rdy2", {31'd0, in_ready}, 32'd1);
    step();
    op = 3'd7; a = 16'h5555; b = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rdy3_low", {31'd0, in_ready}, 32'd0);
      check("bp_y_hold", {16'd0, y}, 32'h1010);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy3_release", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_final_y", {16'd0, y}, 32'hAAAA);
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    step();

    // Accumulate under stall: second beat reads the unconsumed y
    out_ready = 1'b0;
    send(3'd2, 1'b0, 16'h00FF, 16'h0F0F);
    send(3'd1, 1'b1, 16'($urandom), 16'hF000);
    repeat (2) @(negedge clk);
    check("stall_y", {16'd0, y}, 32'h0FF0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_acc_y", {16'd0, y}, 32'hFFF0);
    step();

`ifdef LOGIC_OP_UNIT_FLAGS_EN
    // Flags
    send(3'd2, 1'b0, 16'hAAAA, 16'hAAAA);
    repeat (2) @(negedge clk);
    check("flag_zero1", {31'd0, zero}, 32'd1);
    check("flag_parity1", {31'd0, parity}, 32'd0);
    step();
    send(3'd6, 1'b0, 16'h0001, 16'hFFFF);
    repeat (2) @(negedge clk);
    check("flag_zero2", {31'd0, zero}, 32'd0);
    check("flag_parity2", {31'd0, parity}, 32'd1);
    step();
`endif

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(3'd1, 1'b0, 16'h0F00, 16'h00F0);
    send(3'd7, 1'b0, 16'h1357, 16'h0000);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", {16'd0, y}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale_out", {31'd0, out_valid}, 32'd0);
    end
    step();

    // Randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("final_sb_empty", exp_q.size(), 32'd0);
    check("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
